// File: rtl/pal_pkg.sv
// Shared definitions for the PAL 4-bit code translator family.
// Widths and the preimage finder state encoding.
package pal_pkg;

    localparam int CODE_W    = 4;
    localparam int NUM_CODES = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } pal_inv_state_t;

endpackage

// File: rtl/pal_4b.sv
// Combinational 4-bit PAL code translator.
// Identity except 6->8, 9->6, 14->15.
module pal_4b
    import pal_pkg::*;
(
    input  logic [CODE_W-1:0] i_in,
    output logic [CODE_W-1:0] o_out
);

    always_comb begin
        o_out = i_in;
        unique case (i_in)
            4'd6:    o_out = 4'd8;
            4'd9:    o_out = 4'd6;
            4'd14:   o_out = 4'd15;
            default: o_out = i_in;
        endcase
    end

endmodule

// File: rtl/pal_4b_inv.sv
// Sequential preimage finder for pal_4b: one candidate per clock.
// Optional PAL_INV_MASK_EN adds out_mask and forces full 16-candidate scans.
module pal_4b_inv
    import pal_pkg::*;
#(
    parameter bit DESCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_found,
    output logic [CODE_W-1:0] out_index
`ifdef PAL_INV_MASK_EN
    ,
    output logic [NUM_CODES-1:0] out_mask
`endif
);

    localparam logic [CODE_W-1:0] FIRST = DESCEND ? 4'd15 : 4'd0;
    localparam logic [CODE_W-1:0] LAST  = DESCEND ? 4'd0  : 4'd15;

    pal_inv_state_t    r_state;
    logic [CODE_W-1:0] r_cnt;
    logic [CODE_W-1:0] r_code;
    logic              r_rdy;
    logic              r_valid;
    logic              r_found;
    logic [CODE_W-1:0] r_index;

    logic [CODE_W-1:0] w_img;
    logic              w_hit;
    logic              w_last;
    logic [CODE_W-1:0] w_next;

    pal_4b u_map (
        .i_in  (r_cnt),
        .o_out (w_img)
    );

    assign w_hit  = (w_img == r_code);
    assign w_last = (r_cnt == LAST);
    assign w_next = DESCEND ? (r_cnt - 4'd1) : (r_cnt + 4'd1);

`ifdef PAL_INV_MASK_EN
    logic [NUM_CODES-1:0] r_mask;
    assign out_mask = r_mask;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_code  <= '0;
            r_rdy   <= 1'b1;
            r_valid <= 1'b0;
            r_found <= 1'b0;
            r_index <= '0;
`ifdef PAL_INV_MASK_EN
            r_mask  <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && r_rdy) begin
                        r_code  <= in_code;
                        r_cnt   <= FIRST;
                        r_rdy   <= 1'b0;
                        r_found <= 1'b0;
                        r_index <= '0;
`ifdef PAL_INV_MASK_EN
                        r_mask  <= '0;
`endif
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
`ifdef PAL_INV_MASK_EN
                    // Keep scanning past hits; only the first one sets the index.
                    if (w_hit) begin
                        r_mask[r_cnt] <= 1'b1;
                        if (!r_found) begin
                            r_found <= 1'b1;
                            r_index <= r_cnt;
                        end
                    end
                    if (w_last) begin
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= w_next;
                    end
`else
                    if (w_hit) begin
                        r_found <= 1'b1;
                        r_index <= r_cnt;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else if (w_last) begin
                        r_found <= 1'b0;
                        r_index <= '0;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= w_next;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_rdy   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_rdy;
    assign out_valid = r_valid;
    assign out_found = r_found;
    assign out_index = r_index;

endmodule

// File: tb/tb_pal_4b_inv.sv
// Bench for pal_4b_inv: ascending and descending instances side by side.
// Builds with or without PAL_INV_MASK_EN.
module tb_pal_4b_inv;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_code;
    logic       iv0, iv1, or0, or1;
    logic       ir0, ir1, ov0, ov1, f0, f1;
    logic [3:0] ix0, ix1;
    logic [15:0] m0, m1;

    int tests;
    int fails;

    typedef struct {
        logic [3:0]  code;
        bit          d;
        logic        f;
        logic [3:0]  ix;
        int          lat;
        logic [15:0] m;
    } vec_t;

    typedef struct {
        logic        f;
        logic [3:0]  ix;
        int          lat;
        logic [15:0] m;
    } exp_t;

    exp_t q[$];

    pal_4b_inv #(.DESCEND(1'b0)) u_asc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv0),
        .in_code   (in_code),
        .in_ready  (ir0),
        .out_valid (ov0),
        .out_ready (or0),
        .out_found (f0),
        .out_index (ix0)
`ifdef PAL_INV_MASK_EN
        ,
        .out_mask  (m0)
`endif
    );

    pal_4b_inv #(.DESCEND(1'b1)) u_desc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .in_code   (in_code),
        .in_ready  (ir1),
        .out_valid (ov1),
        .out_ready (or1),
        .out_found (f1),
        .out_index (ix1)
`ifdef PAL_INV_MASK_EN
        ,
        .out_mask  (m1)
`endif
    );

`ifndef PAL_INV_MASK_EN
    assign m0 = '0;
    assign m1 = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic g_ir(bit d);
        return d ? ir1 : ir0;
    endfunction
    function automatic logic g_ov(bit d);
        return d ? ov1 : ov0;
    endfunction
    function automatic logic g_f(bit d);
        return d ? f1 : f0;
    endfunction
    function automatic logic [3:0] g_ix(bit d);
        return d ? ix1 : ix0;
    endfunction
    function automatic logic [15:0] g_m(bit d);
        return d ? m1 : m0;
    endfunction

    task automatic set_iv(bit d, logic v);
        if (d) iv1 = v;
        else   iv0 = v;
    endtask
    task automatic set_or(bit d, logic v);
        if (d) or1 = v;
        else   or0 = v;
    endtask

    task automatic run_req(input bit d, input logic [3:0] code, input exp_t e);
        int   n;
        exp_t g;
        @(negedge clk);
        check("in_ready_before_req", int'(g_ir(d)), 1);
        in_code = code;
        set_iv(d, 1'b1);
        q.push_back(e);
        @(posedge clk);
        #1;
        set_iv(d, 1'b0);
        n = 0;
        while (!g_ov(d) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        g = q.pop_front();
        if (n >= 40) begin
            check("out_valid_timeout", n, g.lat);
            return;
        end
        check("latency", n, g.lat);
        check("out_found", int'(g_f(d)), int'(g.f));
        check("out_index", int'(g_ix(d)), int'(g.ix));
`ifdef PAL_INV_MASK_EN
        check("out_mask", int'(g_m(d)), int'(g.m));
`endif
        @(negedge clk);
        set_or(d, 1'b1);
        @(posedge clk);
        #1;
        set_or(d, 1'b0);
        check("valid_drop_after_hs", int'(g_ov(d)), 0);
        check("ready_after_hs", int'(g_ir(d)), 1);
    endtask

    vec_t vt[13];
    exp_t e;
    int   n;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_code = '0;
        iv0 = 0; iv1 = 0; or0 = 0; or1 = 0;

        vt[0]  = '{4'd5,  1'b0, 1'b1, 4'd5,  6,  16'h0020};
        vt[1]  = '{4'd8,  1'b0, 1'b1, 4'd6,  7,  16'h0140};
        vt[2]  = '{4'd8,  1'b1, 1'b1, 4'd8,  8,  16'h0140};
        vt[3]  = '{4'd15, 1'b0, 1'b1, 4'd14, 15, 16'hC000};
        vt[4]  = '{4'd15, 1'b1, 1'b1, 4'd15, 1,  16'hC000};
        vt[5]  = '{4'd9,  1'b0, 1'b0, 4'd0,  16, 16'h0000};
        vt[6]  = '{4'd6,  1'b0, 1'b1, 4'd9,  10, 16'h0200};
        vt[7]  = '{4'd14, 1'b0, 1'b0, 4'd0,  16, 16'h0000};
        vt[8]  = '{4'd14, 1'b1, 1'b0, 4'd0,  16, 16'h0000};
        vt[9]  = '{4'd0,  1'b1, 1'b1, 4'd0,  16, 16'h0001};
        vt[10] = '{4'd0,  1'b0, 1'b1, 4'd0,  1,  16'h0001};
        vt[11] = '{4'd9,  1'b1, 1'b0, 4'd0,  16, 16'h0000};
        vt[12] = '{4'd6,  1'b1, 1'b1, 4'd9,  7,  16'h0200};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(ir0), 1);
        check("rst_out_valid", int'(ov0), 0);
        check("rst_out_found", int'(f0), 0);
        check("rst_out_index", int'(ix0), 0);
        check("rst_out_mask", int'(m0), 0);
        check("rst_in_ready_desc", int'(ir1), 1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            e.f  = vt[i].f;
            e.ix = vt[i].ix;
            e.m  = vt[i].m;
`ifdef PAL_INV_MASK_EN
            e.lat = 16;
`else
            e.lat = vt[i].lat;
`endif
            run_req(vt[i].d, vt[i].code, e);
        end

        // Hold the result in DONE while a second request knocks.
        @(negedge clk);
        in_code = 4'd8;
        iv0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        n = 0;
        while (!ov0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("hold_valid_seen", int'(ov0), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_code = 4'd3;
            iv0 = 1'b1;
            @(posedge clk);
            #1;
            check("hold_valid", int'(ov0), 1);
            check("hold_found", int'(f0), 1);
            check("hold_index", int'(ix0), 6);
            check("hold_in_ready", int'(ir0), 0);
        end
        @(negedge clk);
        iv0 = 1'b0;
        or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        check("release_valid", int'(ov0), 0);
        check("release_ready", int'(ir0), 1);
        repeat (3) @(posedge clk);
        #1;
        check("no_ghost_request", int'(ov0), 0);
        check("idle_ready", int'(ir0), 1);

        // Reset in the middle of a scan.
        @(negedge clk);
        in_code = 4'd15;
        iv0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midscan_busy", int'(ir0), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", int'(ir0), 1);
        check("midrst_out_valid", int'(ov0), 0);
        check("midrst_out_found", int'(f0), 0);
        check("midrst_out_index", int'(ix0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_no_result", int'(ov0), 0);

        e.f  = 1'b1;
        e.ix = 4'd0;
        e.m  = 16'h0001;
`ifdef PAL_INV_MASK_EN
        e.lat = 16;
`else
        e.lat = 1;
`endif
        run_req(1'b0, 4'd0, e);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pal_4b_inv.md
# pal_4b_inv

Sequential preimage finder for the 4-bit PAL code translator `pal_4b`. It accepts a 4-bit output code and scans candidate inputs one per clock through an internal `pal_4b` instance. It returns the first input whose image equals the code, or reports that no input maps to it. It sits beside the forward translator and gives the decode direction of that code.

## Interface
- `DESCEND`, default 0: scan order. 0 scans candidates 0→15; 1 scans 15→0.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request carries a code to invert.
- `in_code` input 4: target output code.
- `in_ready` output 1: block is idle and accepts a request.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `out_found` output 1: at least one preimage exists.
- `out_index` output 4: first matching candidate in scan order; 0 when not found.
- `out_mask` output 16: bit k set iff map(k)==code. Present only with `PAL_INV_MASK_EN`.

## Operation
- Forward map, input→image: 0→0, 1→1, 2→2, 3→3, 4→4, 5→5, 6→8, 7→7, 8→8, 9→6, 10→10, 11→11, 12→12, 13→13, 14→15, 15→15.
- Codes 9 and 14 have no preimage. Codes 8 and 15 each have two preimages.
- The FSM has three states: IDLE, SCAN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `in_code`, load the candidate counter with 0 (`DESCEND`=0) or 15 (`DESCEND`=1), go to SCAN.
- SCAN, one candidate per cycle:
  - If map(cnt)==code: capture `out_index`=cnt, `out_found`=1, go to DONE.
  - Else, if cnt is the last candidate (15 ascending, 0 descending): `out_found`=0, `out_index`=0, go to DONE.
  - Else step the counter by ±1.
- The 4-bit counter never wraps. The scan terminates at the last candidate.
- DONE:
  - `out_valid`=1; outputs stay stable until `out_ready`.
  - On `out_valid`&&`out_ready`, go to IDLE.
  - `in_ready`=0 in DONE, so a new request is accepted no earlier than the cycle after the handshake.
- `in_valid` outside IDLE is ignored. `in_code` is sampled only at acceptance.
- Reset, including mid-scan: return to IDLE immediately and discard the pending request.
- Reset values: `in_ready`=1, `out_valid`=0, `out_found`=0, `out_index`=0, `out_mask`=0, FSM=IDLE.

## Timing
- Acceptance edge: E0.
- A match on the j-th candidate scanned (j=0..15) asserts `out_valid` after edge E(j+1).
- A miss asserts `out_valid` after E16.
- With `PAL_INV_MASK_EN`, the scan never terminates early: `out_valid` always asserts after E16.
- Outputs are registered. No combinational path from `in_*` to `out_*`.
- Minimum request-to-request period is result latency + 2 cycles: DONE handshake cycle plus IDLE cycle.

## Configuration
- `PAL_INV_MASK_EN` defined:
  - `out_mask` port exists.
  - Bit k of the mask is set during SCAN when map(k)==code.
  - Every scan covers all 16 candidates.
  - `out_index` still reports the first match in scan order.
  - The mask clears at acceptance.
- Not defined:
  - No `out_mask` port and no mask register.
  - The scan stops at the first match.

## Structure
- Shared package `pal_pkg`:
  - `CODE_W`=4, `NUM_CODES`=16.
  - FSM state enum `pal_inv_state_t` {IDLE, SCAN, DONE}.
- Sub-module: one instance of the existing combinational `pal_4b`, driven by the candidate counter. Its output is compared against the latched code.
- No duplicate map equations are allowed in this block.

## Test plan
- Reset, then code 5, `DESCEND`=0 → `out_found`=1, `out_index`=5, `out_valid` after E6 (mask build: E16, `out_mask`=0x0020).
- Code 8, `DESCEND`=0 → index 6, found=1.
- Code 8, `DESCEND`=1 → index 8, found=1.
- Code 15 → index 14 (`DESCEND`=0) or 15 (`DESCEND`=1), found=1.
- Mask build: code 15 → `out_mask`=0xC000.
- Code 9 → found=0, index=0, `out_valid` after E16 (mask build: `out_mask`=0x0000).
- Code 6 → index 9.
- Code 14 → found=0.
- Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, a second `in_valid` is ignored.
- Release `out_ready` → IDLE on the next cycle.
- Accept code 15, assert `rst_n`=0 at E3 → all outputs at reset values immediately, `in_ready`=1.
- After reset release, code 0 → index 0 after E1.
